// File: rtl/exu_commit_bjp_pkg.sv
// Shared definitions for the branch/jump commit unit.
// Holds the PC width, FSM state encoding and fall-through increment.
package exu_commit_bjp_pkg;

  localparam int unsigned PC_SIZE          = 32;
  localparam int unsigned CNT_W_DFLT       = 32;
  localparam int unsigned BJP_FALLTHRU_INC = 4;

  typedef enum logic {
    BJP_CMT_IDLE  = 1'b0,
    BJP_CMT_FLUSH = 1'b1
  } bjp_cmt_state_e;

endpackage

// File: rtl/bjp_perf_cnt.sv
// Wrapping performance counter with a single-cycle increment enable.
module bjp_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/exu_commit_bjp.sv
// Branch/jump commit: checks the resolved direction against the IFU prediction,
// holds a redirect request until the IFU accepts it and counts branches/mispredicts.
module exu_commit_bjp
  import exu_commit_bjp_pkg::*;
#(
  parameter int unsigned PC_SIZE = exu_commit_bjp_pkg::PC_SIZE,
  parameter int unsigned CNT_W   = CNT_W_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_jump,
  input  logic               cmt_i_prdt,
  input  logic               cmt_i_rslv,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic [PC_SIZE-1:0] cmt_i_tgt,
  output logic               flush_o_valid,
  input  logic               flush_o_ready,
  output logic [PC_SIZE-1:0] flush_o_pc,
  output logic               retire_o,
  output logic [CNT_W-1:0]   perf_bjp_cnt,
  output logic [CNT_W-1:0]   perf_mis_cnt
);

  bjp_cmt_state_e     state_q;
  bjp_cmt_state_e     state_d;
  logic [PC_SIZE-1:0] flush_pc_q;
  logic [PC_SIZE-1:0] flush_pc_d;
  logic               retire_q;
  logic               retire_d;

  logic               taken;
  logic               mis;
  logic               hs;
  logic [PC_SIZE-1:0] redirect_pc;

  // Jumps are always taken; the not-taken path wraps modulo 2^PC_SIZE.
  assign taken       = cmt_i_jump | cmt_i_rslv;
  assign mis         = cmt_i_bjp & (taken != cmt_i_prdt);
  assign redirect_pc = taken ? cmt_i_tgt : (cmt_i_pc + PC_SIZE'(BJP_FALLTHRU_INC));
  assign hs          = cmt_i_valid & cmt_i_ready;

  // Ready/valid are pure state decodes so neither side sees a combinational loop.
  always_comb begin
    state_d       = state_q;
    flush_pc_d    = flush_pc_q;
    retire_d      = 1'b0;
    cmt_i_ready   = 1'b0;
    flush_o_valid = 1'b0;
    unique case (state_q)
      BJP_CMT_IDLE: begin
        cmt_i_ready = 1'b1;
        if (cmt_i_valid) begin
          retire_d = 1'b1;
          if (mis) begin
            flush_pc_d = redirect_pc;
            state_d    = BJP_CMT_FLUSH;
          end
        end
      end
      BJP_CMT_FLUSH: begin
        flush_o_valid = 1'b1;
        if (flush_o_ready) state_d = BJP_CMT_IDLE;
      end
      default: state_d = BJP_CMT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BJP_CMT_IDLE;
      flush_pc_q <= '0;
      retire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
      retire_q   <= retire_d;
    end
  end

  assign flush_o_pc = flush_pc_q;
  assign retire_o   = retire_q;

  bjp_perf_cnt #(.W(CNT_W)) u_bjp_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hs & cmt_i_bjp),
    .cnt (perf_bjp_cnt)
  );

  bjp_perf_cnt #(.W(CNT_W)) u_mis_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hs & mis),
    .cnt (perf_mis_cnt)
  );

endmodule

// File: tb/tb_exu_commit_bjp.sv
// Directed bench for exu_commit_bjp: hand-computed expectations checked after each edge.
module tb_exu_commit_bjp;

  logic        clk;
  logic        rst;
  logic        cmt_i_valid;
  logic        cmt_i_ready;
  logic        cmt_i_bjp;
  logic        cmt_i_jump;
  logic        cmt_i_prdt;
  logic        cmt_i_rslv;
  logic [31:0] cmt_i_pc;
  logic [31:0] cmt_i_tgt;
  logic        flush_o_valid;
  logic        flush_o_ready;
  logic [31:0] flush_o_pc;
  logic        retire_o;
  logic [31:0] perf_bjp_cnt;
  logic [31:0] perf_mis_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  exu_commit_bjp #(.PC_SIZE(32), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmt_i_valid   (cmt_i_valid),
    .cmt_i_ready   (cmt_i_ready),
    .cmt_i_bjp     (cmt_i_bjp),
    .cmt_i_jump    (cmt_i_jump),
    .cmt_i_prdt    (cmt_i_prdt),
    .cmt_i_rslv    (cmt_i_rslv),
    .cmt_i_pc      (cmt_i_pc),
    .cmt_i_tgt     (cmt_i_tgt),
    .flush_o_valid (flush_o_valid),
    .flush_o_ready (flush_o_ready),
    .flush_o_pc    (flush_o_pc),
    .retire_o      (retire_o),
    .perf_bjp_cnt  (perf_bjp_cnt),
    .perf_mis_cnt  (perf_mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bjp, input logic jump, input logic prdt, input logic rslv,
                       input logic [31:0] pc, input logic [31:0] tgt);
    cmt_i_valid = 1'b1;
    cmt_i_bjp   = bjp;
    cmt_i_jump  = jump;
    cmt_i_prdt  = prdt;
    cmt_i_rslv  = rslv;
    cmt_i_pc    = pc;
    cmt_i_tgt   = tgt;
  endtask

  initial begin
    rst           = 1'b1;
    cmt_i_valid   = 1'b0;
    cmt_i_bjp     = 1'b0;
    cmt_i_jump    = 1'b0;
    cmt_i_prdt    = 1'b0;
    cmt_i_rslv    = 1'b0;
    cmt_i_pc      = '0;
    cmt_i_tgt     = '0;
    flush_o_ready = 1'b0;
    step();
    step();
    check("rst_ready",  32'(cmt_i_ready),   32'd1);
    check("rst_fvalid", 32'(flush_o_valid), 32'd0);
    check("rst_fpc",    flush_o_pc,         32'h0);
    check("rst_retire", 32'(retire_o),      32'd0);
    check("rst_bjpcnt", perf_bjp_cnt,       32'd0);
    check("rst_miscnt", perf_mis_cnt,       32'd0);
    rst = 1'b0;
    step();

    // Correct not-taken branch
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0800);
    step();
    cmt_i_valid = 1'b0;
    check("nt_retire", 32'(retire_o),      32'd1);
    check("nt_fvalid", 32'(flush_o_valid), 32'd0);
    check("nt_ready",  32'(cmt_i_ready),   32'd1);
    check("nt_bjpcnt", perf_bjp_cnt,       32'd1);
    check("nt_miscnt", perf_mis_cnt,       32'd0);
    step();
    check("nt_retire_pulse", 32'(retire_o), 32'd0);

    // Predicted taken, resolved not taken: redirect to pc+4, held for 3 cycles
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h1234_5678);
    step();
    cmt_i_valid   = 1'b0;
    flush_o_ready = 1'b0;
    check("mis_fvalid", 32'(flush_o_valid), 32'd1);
    check("mis_fpc",    flush_o_pc,         32'h8000_0014);
    check("mis_ready",  32'(cmt_i_ready),   32'd0);
    check("mis_retire", 32'(retire_o),      32'd1);
    check("mis_bjpcnt", perf_bjp_cnt,       32'd2);
    check("mis_miscnt", perf_mis_cnt,       32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_fvalid", 32'(flush_o_valid), 32'd1);
      check("hold_fpc",    flush_o_pc,         32'h8000_0014);
      check("hold_ready",  32'(cmt_i_ready),   32'd0);
    end
    flush_o_ready = 1'b1;
    step();
    check("rel_fvalid", 32'(flush_o_valid), 32'd0);
    check("rel_ready",  32'(cmt_i_ready),   32'd1);

    // Jump predicted not taken, IFU ready already high: one-cycle flush
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0100, 32'h8000_1000);
    step();
    cmt_i_valid = 1'b0;
    check("jmp_fvalid", 32'(flush_o_valid), 32'd1);
    check("jmp_fpc",    flush_o_pc,         32'h8000_1000);
    check("jmp_miscnt", perf_mis_cnt,       32'd2);
    check("jmp_bjpcnt", perf_bjp_cnt,       32'd3);
    step();
    check("jmp_rel_fvalid", 32'(flush_o_valid), 32'd0);
    check("jmp_rel_ready",  32'(cmt_i_ready),   32'd1);

    // Jump predicted taken: correct, no flush
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0104, 32'h8000_1000);
    step();
    cmt_i_valid = 1'b0;
    check("jok_fvalid", 32'(flush_o_valid), 32'd0);
    check("jok_retire", 32'(retire_o),      32'd1);
    check("jok_bjpcnt", perf_bjp_cnt,       32'd4);
    check("jok_miscnt", perf_mis_cnt,       32'd2);

    // Fall-through wraps to zero
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h4444_0000);
    step();
    cmt_i_valid = 1'b0;
    check("wrap_fvalid", 32'(flush_o_valid), 32'd1);
    check("wrap_fpc",    flush_o_pc,         32'h0000_0000);
    check("wrap_miscnt", perf_mis_cnt,       32'd3);
    step();
    check("wrap_rel", 32'(flush_o_valid), 32'd0);

    // Back-to-back: valid stays high across the flush; second result stalls
    flush_o_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0200, 32'h8000_2000);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0300, 32'h8000_3000);
    check("b2b_fvalid", 32'(flush_o_valid), 32'd1);
    check("b2b_fpc",    flush_o_pc,         32'h8000_2000);
    check("b2b_ready",  32'(cmt_i_ready),   32'd0);
    check("b2b_bjpcnt", perf_bjp_cnt,       32'd6);
    check("b2b_miscnt", perf_mis_cnt,       32'd4);
    step();
    check("b2b_stall_retire", 32'(retire_o), 32'd0);
    check("b2b_stall_bjpcnt", perf_bjp_cnt,  32'd6);
    check("b2b_stall_fpc",    flush_o_pc,    32'h8000_2000);
    flush_o_ready = 1'b1;
    step();
    check("b2b_rel_fvalid", 32'(flush_o_valid), 32'd0);
    check("b2b_rel_ready",  32'(cmt_i_ready),   32'd1);
    check("b2b_rel_retire", 32'(retire_o),      32'd0);
    check("b2b_rel_bjpcnt", perf_bjp_cnt,       32'd6);
    step();
    cmt_i_valid = 1'b0;
    check("b2b_acc_retire", 32'(retire_o),      32'd1);
    check("b2b_acc_fvalid", 32'(flush_o_valid), 32'd0);
    check("b2b_acc_bjpcnt", perf_bjp_cnt,       32'd7);
    check("b2b_acc_miscnt", perf_mis_cnt,       32'd4);

    // Reset while a flush is pending
    flush_o_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0400, 32'h0);
    step();
    cmt_i_valid = 1'b0;
    check("rf_fvalid", 32'(flush_o_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rf_fvalid_clr", 32'(flush_o_valid), 32'd0);
    check("rf_ready",      32'(cmt_i_ready),   32'd1);
    check("rf_fpc",        flush_o_pc,         32'h0);
    check("rf_bjpcnt",     perf_bjp_cnt,       32'd0);
    check("rf_miscnt",     perf_mis_cnt,       32'd0);

    // Non-branch with a stale prediction: retire only
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0500, 32'h8000_5000);
    step();
    cmt_i_valid = 1'b0;
    check("nb_retire", 32'(retire_o),      32'd1);
    check("nb_fvalid", 32'(flush_o_valid), 32'd0);
    check("nb_bjpcnt", perf_bjp_cnt,       32'd0);
    check("nb_miscnt", perf_mis_cnt,       32'd0);
    step();
    check("nb_idle_fvalid", 32'(flush_o_valid), 32'd0);
    check("nb_retire_pulse", 32'(retire_o),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/exu_commit_bjp.md
# exu_commit_bjp

Branch/jump commit unit at the consumer end of the EXU branch-jump result handshake. It accepts one resolved branch or jump per handshake and compares the resolved direction with the IFU prediction. On a mispredict it holds a flush/redirect request to the IFU until the IFU accepts it, and it keeps branch/mispredict performance counters. It sits between the EXU ALU branch-jump path and the IFU PC-redirect port.

## Interface
- `PC_SIZE`, default 32: PC width.
- `CNT_W`, default 32: performance counter width.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmt_i_valid`  in  1  branch-jump result valid.
- `cmt_i_ready`  out  1  commit accepts the result.
- `cmt_i_bjp`  in  1  instruction is a branch/jump. If 0, the result is retired with no check.
- `cmt_i_jump`  in  1  unconditional jump (jal/jalr); resolved taken is forced to 1.
- `cmt_i_prdt`  in  1  IFU predicted taken.
- `cmt_i_rslv`  in  1  resolved taken (conditional branches only).
- `cmt_i_pc`  in  PC_SIZE  PC of the instruction.
- `cmt_i_tgt`  in  PC_SIZE  resolved taken target.
- `flush_o_valid`  out  1  flush/redirect request.
- `flush_o_ready`  in  1  IFU accepts the flush.
- `flush_o_pc`  out  PC_SIZE  redirect PC.
- `retire_o`  out  1  one-cycle pulse for each accepted result.
- `perf_bjp_cnt`  out  CNT_W  number of branches/jumps committed.
- `perf_mis_cnt`  out  CNT_W  number of mispredicts.

## Operation
- Resolved taken: `taken = cmt_i_jump | cmt_i_rslv`.
- Mispredict: `mis = cmt_i_bjp & (taken != cmt_i_prdt)`.
- Redirect PC:
  - taken: `cmt_i_tgt`.
  - not taken: `cmt_i_pc + 4`, computed modulo 2^PC_SIZE; a wrap to 0 is legal.
- States:
  - IDLE:
    - `cmt_i_ready = 1`, `flush_o_valid = 0`.
    - On handshake (`cmt_i_valid & cmt_i_ready`): `retire_o = 1` next cycle. If `mis`, latch the redirect PC into `flush_pc_q` and go to FLUSH.
  - FLUSH:
    - `cmt_i_ready = 0`, `flush_o_valid = 1`, `flush_o_pc = flush_pc_q`, held stable.
    - On `flush_o_ready = 1`, return to IDLE. The next result may be accepted in the cycle after that.
- `flush_o_valid` is never dropped before it is accepted. `flush_o_pc` never changes while `flush_o_valid = 1`.
- Counters:
  - `perf_bjp_cnt` increments on each handshake with `cmt_i_bjp = 1`.
  - `perf_mis_cnt` increments on each handshake with `mis = 1`.
  - Both wrap to 0 at 2^CNT_W.
- Results with `cmt_i_bjp = 0` never flush and never count; they only retire.

## Timing
- Reset values:
  - State IDLE.
  - `cmt_i_ready = 1` (combinational from state).
  - `flush_o_valid = 0`, `flush_o_pc = 0`.
  - `retire_o = 0`.
  - Both counters 0.
- Latency: handshake in cycle N gives `flush_o_valid = 1` and `retire_o = 1` in cycle N+1. Counters show the new value in N+1.
- Minimum flush duration is 1 cycle, when `flush_o_ready` is already high in N+1.
- `cmt_i_ready` depends only on state, never combinationally on `cmt_i_valid`.
- `flush_o_valid` depends only on state, never on `flush_o_ready`.
- Reset mid-FLUSH: next cycle IDLE, the pending flush is dropped, counters are cleared.
- `cmt_i_valid` during FLUSH is stalled, not dropped. The upstream holds its payload; it is accepted on the first IDLE cycle.
- There is no simultaneous accept-and-release: in the cycle FLUSH is released, `cmt_i_ready` is still 0.

## Structure
- The shared defines file holds:
  - `PC_SIZE` and the state encoding: `BJP_CMT_IDLE = 1'b0`, `BJP_CMT_FLUSH = 1'b1`.
  - The constant `BJP_FALLTHRU_INC = 4`.
- One sub-module is natural: `bjp_perf_cnt`, a parameterized wrapping counter with an increment enable, instantiated twice.
- All other logic stays flat in `exu_commit_bjp`.

## Test plan
- Correct not-taken branch: bjp=1, jump=0, prdt=0, rslv=0, pc=0x80000000 → retire pulse, no flush, bjp_cnt=1, mis_cnt=0.
- Mispredict not-taken: prdt=1, rslv=0, pc=0x80000010 → next cycle flush_o_valid=1, flush_o_pc=0x80000014. Hold flush_o_ready=0 for 3 cycles → pc stable, cmt_i_ready=0 throughout. Ready=1 → IDLE. mis_cnt=1.
- Jump predicted not-taken: jump=1, prdt=0, tgt=0x80001000 → flush_o_pc=0x80001000. With prdt=1 instead → no flush.
- Wrap: pc=0xFFFFFFFC, prdt=1, rslv=0 → flush_o_pc=0x00000000.
- Back-to-back: valid held high with a mispredict followed by a correct branch → second result accepted exactly one cycle after the flush handshake; payload intact; bjp_cnt=2.
- Reset asserted during FLUSH → next cycle flush_o_valid=0, cmt_i_ready=1, counters 0. Non-bjp result (bjp=0, prdt=1) → retire only, no flush.
